// File: rtl/ble_adv_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ble_adv_scan_scheduler: hops the BLE receiver over channels 37/38/39.
// Each hop is a firmware LO retune, a settle wait, then a sniff dwell that a
// detection can extend. Optional statistics counters are built with the
// SCAN_STATS_EN macro.
// Revision: 1.0
// ============================================================================
module ble_adv_scan_scheduler #(
  parameter int DWELL_CYCLES  = 1_600_000,
  parameter int SETTLE_CYCLES = 1_600,
  parameter int HOLD_CYCLES   = 16_000,
  parameter int TUNE_TIMEOUT  = 160_000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             packet_detected_i,
  input  logic             tune_ack_i,
  output logic             tune_req_o,
  output logic [5:0]       tune_channel_o,
  output logic [5:0]       channel_o,
  output logic             sniff_en_o,
  output logic             tune_err_o,
  output logic [CNT_W-1:0] pkt_count_o,
  output logic [CNT_W-1:0] hop_count_o
);

  localparam int c_max_ab = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int c_max_cd = (HOLD_CYCLES > TUNE_TIMEOUT) ? HOLD_CYCLES : TUNE_TIMEOUT;
  localparam int c_max    = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_tw     = $clog2(c_max) + 1;

  localparam logic [c_tw-1:0] c_dwell_last  = c_tw'(DWELL_CYCLES - 1);
  localparam logic [c_tw-1:0] c_settle_last = c_tw'(SETTLE_CYCLES - 1);
  localparam logic [c_tw-1:0] c_hold_last   = c_tw'(HOLD_CYCLES - 1);
  localparam logic [c_tw-1:0] c_to_last     = c_tw'(TUNE_TIMEOUT - 1);

  localparam logic [5:0] c_ch37 = 6'd37;
  localparam logic [5:0] c_ch38 = 6'd38;
  localparam logic [5:0] c_ch39 = 6'd39;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TUNE   = 3'd1,
    S_SETTLE = 3'd2,
    S_LISTEN = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [c_tw-1:0] timer_q, timer_d;
  logic            tune_req_q, tune_req_d;
  logic            sniff_en_q, sniff_en_d;
  logic            tune_err_q, tune_err_d;
  logic [5:0]      channel_q, channel_d;
  logic [5:0]      tune_ch_q, tune_ch_d;
  logic            first_q, first_d;
  logic            det_q;
  logic            det_edge;
  logic            pkt_inc;
  logic            hop_inc;

  function automatic logic [5:0] next_ch(input logic [5:0] ch);
    case (ch)
      c_ch37:  next_ch = c_ch38;
      c_ch38:  next_ch = c_ch39;
      default: next_ch = c_ch37;
    endcase
  endfunction

  assign det_edge = packet_detected_i & ~det_q & sniff_en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      tune_req_q <= 1'b0;
      sniff_en_q <= 1'b0;
      tune_err_q <= 1'b0;
      channel_q  <= c_ch37;
      tune_ch_q  <= c_ch37;
      first_q    <= 1'b1;
      det_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tune_req_q <= tune_req_d;
      sniff_en_q <= sniff_en_d;
      tune_err_q <= tune_err_d;
      channel_q  <= channel_d;
      tune_ch_q  <= tune_ch_d;
      first_q    <= first_d;
      det_q      <= packet_detected_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    tune_req_d = tune_req_q;
    sniff_en_d = sniff_en_q;
    tune_err_d = tune_err_q;
    channel_d  = channel_q;
    tune_ch_d  = tune_ch_q;
    first_d    = first_q;
    pkt_inc    = 1'b0;
    hop_inc    = 1'b0;
    if (!en_i) begin
      state_d    = S_IDLE;
      timer_d    = '0;
      tune_req_d = 1'b0;
      sniff_en_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_TUNE;
          timer_d    = '0;
          tune_req_d = 1'b1;
          tune_ch_d  = first_q ? c_ch37 : next_ch(channel_q);
        end
        S_TUNE: begin
          // A low tune_req here is the one-cycle gap between retry attempts.
          if (!tune_req_q) begin
            tune_req_d = 1'b1;
            timer_d    = '0;
          end else if (tune_ack_i) begin
            state_d    = S_SETTLE;
            timer_d    = '0;
            tune_req_d = 1'b0;
            channel_d  = tune_ch_q;
            first_d    = 1'b0;
            hop_inc    = 1'b1;
          end else if (timer_q == c_to_last) begin
            tune_err_d = 1'b1;
            tune_ch_d  = next_ch(tune_ch_q);
            tune_req_d = 1'b0;
            timer_d    = '0;
          end
        end
        S_SETTLE: begin
          if (timer_q == c_settle_last) begin
            state_d    = S_LISTEN;
            timer_d    = '0;
            sniff_en_d = 1'b1;
          end
        end
        S_LISTEN, S_HOLD: begin
          if (det_edge) begin
            state_d = S_HOLD;
            timer_d = '0;
            pkt_inc = 1'b1;
          end else if ((state_q == S_LISTEN && timer_q == c_dwell_last) ||
                       (state_q == S_HOLD && timer_q == c_hold_last)) begin
            state_d    = S_TUNE;
            timer_d    = '0;
            sniff_en_d = 1'b0;
            tune_req_d = 1'b1;
            tune_ch_d  = next_ch(channel_q);
          end
        end
        default: begin
          state_d    = S_IDLE;
          timer_d    = '0;
          tune_req_d = 1'b0;
          sniff_en_d = 1'b0;
        end
      endcase
    end
  end

  assign tune_req_o     = tune_req_q;
  assign tune_channel_o = tune_ch_q;
  assign channel_o      = channel_q;
  assign sniff_en_o     = sniff_en_q;
  assign tune_err_o     = tune_err_q;

`ifdef SCAN_STATS_EN
  logic [CNT_W-1:0] pkt_q;
  logic [CNT_W-1:0] hop_q;

  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q <= '0;
      hop_q <= '0;
    end else begin
      if (pkt_inc && (pkt_q != '1)) pkt_q <= pkt_q + 1'b1;
      if (hop_inc && (hop_q != '1)) hop_q <= hop_q + 1'b1;
    end
  end

  assign pkt_count_o = pkt_q;
  assign hop_count_o = hop_q;
`else
  logic unused_stats;
  assign unused_stats = pkt_inc ^ hop_inc;
  assign pkt_count_o  = '0;
  assign hop_count_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ble_adv_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ble_adv_scan_scheduler: event scoreboard for the BLE scan scheduler.
// Revision: 1.0
// ============================================================================
module tb_ble_adv_scan_scheduler;

  localparam int DW = 100;
  localparam int ST = 10;
  localparam int HD = 20;
  localparam int TO = 50;
  localparam int CW = 4;
`ifdef SCAN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K_REQ = 0;
  localparam int K_WIN = 1;
  localparam int K_ERR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          pd  = 1'b0;
  logic          ack = 1'b0;
  logic          tune_req;
  logic [5:0]    tune_ch;
  logic [5:0]    channel;
  logic          sniff_en;
  logic          tune_err;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] hop_count;

  ble_adv_scan_scheduler #(
    .DWELL_CYCLES (DW),
    .SETTLE_CYCLES(ST),
    .HOLD_CYCLES  (HD),
    .TUNE_TIMEOUT (TO),
    .CNT_W        (CW)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .en_i             (en),
    .packet_detected_i(pd),
    .tune_ack_i       (ack),
    .tune_req_o       (tune_req),
    .tune_channel_o   (tune_ch),
    .channel_o        (channel),
    .sniff_en_o       (sniff_en),
    .tune_err_o       (tune_err),
    .pkt_count_o      (pkt_count),
    .hop_count_o      (hop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  ev_t q[$];
  int  nvec = 0;
  int  nbad = 0;
  int  m_hop;
  int  m_pkt;
  int  m_err;

  function automatic int expc(input int v);
    if (!STATS) return 0;
    return (v > 15) ? 15 : v;
  endfunction

  function automatic int nxt(input int c);
    return (c == 37) ? 38 : (c == 38) ? 39 : 37;
  endfunction

  function automatic string kname(input int k);
    return (k == K_REQ) ? "req" : (k == K_WIN) ? "window" : "tune_err";
  endfunction

  task automatic push(input int k, input int a, input int b, input int c, input int d);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: turns output transitions into events and checks them in order.
  // REQ: a=tune_channel b=low run before rise c=hop_count d=tune_err
  // WIN: a=channel b=sniff_en high run c=settle run d=pkt_count
  // ERR: a=tune_channel b=preceding tune_req high run c=tune_err d=hop_count
  task automatic observe(input int k, input int a, input int b, input int c, input int d);
    ev_t e;
    nvec++;
    if (q.size() == 0) begin
      nbad++;
      $display("FAIL unexpected %s event: a=%0d b=%0d c=%0d d=%0d", kname(k), a, b, c, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.a != a || (e.b >= 0 && e.b != b) || e.c != c || e.d != d) begin
        nbad++;
        $display("FAIL %s event: got %s a=%0d b=%0d c=%0d d=%0d expected %s a=%0d b=%0d c=%0d d=%0d",
                 kname(e.kind), kname(k), a, b, c, d, kname(e.kind), e.a, e.b, e.c, e.d);
      end
    end
  endtask

  int p_req, p_sn, p_err, gap, hi, lead, lead_l, req_hi;

  always @(negedge clk) begin
    if (!rst) begin
      p_req = 0; p_sn = 0; p_err = 0; gap = 0; hi = 0; lead = 0; lead_l = 0; req_hi = 0;
    end else begin
      if (p_sn == 1 && !sniff_en)
        observe(K_WIN, int'(channel), hi, lead_l, int'(pkt_count));
      if (p_err == 0 && tune_err)
        observe(K_ERR, int'(tune_ch), req_hi, int'(tune_err), int'(hop_count));
      if (p_req == 0 && tune_req)
        observe(K_REQ, int'(tune_ch), gap, int'(hop_count), int'(tune_err));
      if (sniff_en) hi = (p_sn == 1) ? hi + 1 : 1;
      if (p_sn == 0 && sniff_en) lead_l = lead;
      if (tune_req) lead = 0;
      else if (!sniff_en) lead = lead + 1;
      if (tune_req) begin
        req_hi = (p_req == 1) ? req_hi + 1 : 1;
        gap    = 0;
      end else begin
        gap = gap + 1;
      end
      p_req = int'(tune_req);
      p_sn  = int'(sniff_en);
      p_err = int'(tune_err);
    end
  end

  // Waits for a request on channel ch, then acks d cycles after it appears.
  task automatic ack_after(input int ch, input int d);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (tune_req && tune_ch == 6'(ch)) found = 1'b1;
    end
    if (!found) begin
      nvec++; nbad++;
      $display("FAIL req wait ch%0d: got no request expected one within 600 cycles", ch);
    end
    repeat (d - 1) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_sniff();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (sniff_en) found = 1'b1;
    end
    if (!found) begin
      nvec++; nbad++;
      $display("FAIL sniff wait: got sniff_en=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " tune_req"}, int'(tune_req), 0);
    chk({tag, " sniff_en"}, int'(sniff_en), 0);
    chk({tag, " tune_err"}, int'(tune_err), 0);
    chk({tag, " channel"}, int'(channel), 37);
    chk({tag, " tune_channel"}, int'(tune_ch), 37);
    chk({tag, " counters"}, int'(pkt_count) + int'(hop_count), 0);
  endtask

  initial begin
    int ch;
    bit found;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b1;
    @(negedge clk);

    // Plain scan: four hops, full dwell each.
    m_hop = 0; m_pkt = 0; m_err = 0;
    push(K_REQ, 37, -1, 0, 0);
    en = 1'b1;
    ch = 37;
    for (int i = 0; i < 4; i++) begin
      ack_after(ch, 3);
      m_hop++;
      push(K_WIN, ch, DW, ST, expc(m_pkt));
      push(K_REQ, nxt(ch), ST + DW, expc(m_hop), m_err);
      ch = nxt(ch);
    end

    // Single detection, then a detection that restarts the hold.
    ack_after(38, 3);
    m_hop++; m_pkt += 1;
    push(K_WIN, 38, 40 + HD, ST, expc(m_pkt));
    push(K_REQ, 39, ST + 40 + HD, expc(m_hop), m_err);
    wait_sniff();
    repeat (39) @(negedge clk);
    pd = 1'b1; @(negedge clk); pd = 1'b0;

    ack_after(39, 3);
    m_hop++; m_pkt += 2;
    push(K_WIN, 39, 40 + 15 + HD, ST, expc(m_pkt));
    push(K_REQ, 37, ST + 40 + 15 + HD, expc(m_hop), m_err);
    wait_sniff();
    repeat (39) @(negedge clk);
    pd = 1'b1; @(negedge clk); pd = 1'b0;
    repeat (14) @(negedge clk);
    pd = 1'b1; @(negedge clk); pd = 1'b0;

    // Request 37 is left unanswered: timeout, retry on 38.
    m_err = 1;
    push(K_ERR, 38, TO, 1, expc(m_hop));
    push(K_REQ, 38, 1, expc(m_hop), 1);
    ack_after(38, 3);
    m_hop++;
    push(K_WIN, 38, DW, ST, expc(m_pkt));
    push(K_REQ, 39, ST + DW, expc(m_hop), 1);

    // Detect edge on the last dwell cycle, held high into the hold.
    ack_after(39, 3);
    m_hop++; m_pkt++;
    push(K_WIN, 39, DW + HD, ST, expc(m_pkt));
    push(K_REQ, 37, ST + DW + HD, expc(m_hop), 1);
    wait_sniff();
    repeat (DW - 1) @(negedge clk);
    pd = 1'b1;
    repeat (5) @(negedge clk);
    pd = 1'b0;

    // Enable dropped mid-settle.
    ack_after(37, 3);
    m_hop++;
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("settle drop tune_req", int'(tune_req), 0);
    chk("settle drop sniff_en", int'(sniff_en), 0);
    push(K_REQ, 38, 8, expc(m_hop), 1);
    repeat (2) @(negedge clk);
    en = 1'b1;

    // Enable dropped mid-hold.
    ack_after(38, 3);
    m_hop++; m_pkt++;
    push(K_WIN, 38, 16, ST, expc(m_pkt));
    wait_sniff();
    repeat (9) @(negedge clk);
    pd = 1'b1; @(negedge clk); pd = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("hold drop tune_req", int'(tune_req), 0);
    chk("hold drop sniff_en", int'(sniff_en), 0);
    push(K_REQ, 39, ST + 16 + 3, expc(m_hop), 1);
    repeat (2) @(negedge clk);
    en = 1'b1;

    // Asynchronous reset while a request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tune_req) found = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    #1;
    reset_checks("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Twenty detections in one window: pkt_count saturates.
    m_hop = 0; m_pkt = 0; m_err = 0;
    push(K_REQ, 37, -1, 0, 0);
    en = 1'b1;
    ack_after(37, 3);
    m_hop++; m_pkt = 20;
    push(K_WIN, 37, 39 + HD, ST, expc(m_pkt));
    push(K_REQ, 38, ST + 39 + HD, expc(m_hop), 0);
    wait_sniff();
    for (int i = 0; i < 20; i++) begin
      pd = 1'b1; @(negedge clk);
      pd = 1'b0; @(negedge clk);
    end

    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    en = 1'b0;
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      nvec++; nbad++;
      $display("FAIL missing %s event: got none expected a=%0d b=%0d c=%0d d=%0d",
               kname(e.kind), e.a, e.b, e.c, e.d);
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
`default_nettype wire
